// File: rtl/deci_pkg.sv
// Shared types and helpers for the decimal key entry controller.
package deci_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned KEY_W = 10;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        CAPTURE,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        KEYS_ZERO,
        KEYS_SINGLE,
        KEYS_MULTI
    } key_kind_t;

    // Classify a key vector as no key, exactly one key, or several keys.
    function automatic key_kind_t key_kind(input logic [KEY_W-1:0] k);
        if (k == '0) begin
            return KEYS_ZERO;
        end
        if ((k & (k - KEY_W'(1))) == '0) begin
            return KEYS_SINGLE;
        end
        return KEYS_MULTI;
    endfunction

endpackage

// File: rtl/dec_onehot_to_bcd.sv
// One-hot decimal key pattern to BCD digit; non-one-hot patterns map to 0.
module dec_onehot_to_bcd
    import deci_pkg::*;
(
    input  logic [KEY_W-1:0] onehot,
    output logic [BCD_W-1:0] bcd_c
);

    always_comb begin
        bcd_c = '0;
        case (onehot)
            10'b00_0000_0001: bcd_c = 4'd0;
            10'b00_0000_0010: bcd_c = 4'd1;
            10'b00_0000_0100: bcd_c = 4'd2;
            10'b00_0000_1000: bcd_c = 4'd3;
            10'b00_0001_0000: bcd_c = 4'd4;
            10'b00_0010_0000: bcd_c = 4'd5;
            10'b00_0100_0000: bcd_c = 4'd6;
            10'b00_1000_0000: bcd_c = 4'd7;
            10'b01_0000_0000: bcd_c = 4'd8;
            10'b10_0000_0000: bcd_c = 4'd9;
            default:          bcd_c = 4'd0;
        endcase
    end

endmodule

// File: rtl/deci_entry_ctrl.sv
// Debounced decimal key entry into a BCD shift buffer, presented downstream
// over valid/ready once the buffer is full.
module deci_entry_ctrl
    import deci_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KEY_W-1:0]              key,
    input  logic                          clear,
    input  logic                          out_ready,
    output logic [BCD_W*NUM_DIGITS-1:0]   digits,
    output logic [2:0]                    digit_count,
    output logic                          out_valid,
    output logic                          key_err
);

    localparam int unsigned     DIG_W    = BCD_W * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       FULL     = 3'(NUM_DIGITS);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [KEY_W-1:0]   latched, latched_nxt;
    logic               key_err_nxt;
    logic               capture_c;
    logic [BCD_W-1:0]   bcd_c;
    key_kind_t          kind_c;

    assign kind_c = key_kind(key);

    dec_onehot_to_bcd u_enc (
        .onehot (latched),
        .bcd_c  (bcd_c)
    );

    // Controller state, debounce counter and latched key pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            latched <= '0;
            key_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            latched <= latched_nxt;
            key_err <= key_err_nxt;
        end
    end

    // Next-state logic: press debounce, capture, then release debounce
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        latched_nxt = latched;
        key_err_nxt = 1'b0;
        capture_c   = 1'b0;
        case (state)
            IDLE: begin
                if (kind_c == KEYS_SINGLE) begin
                    latched_nxt = key;
                    cnt_nxt     = '0;
                    state_nxt   = DEBOUNCE;
                end else if (kind_c == KEYS_MULTI) begin
                    key_err_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = RELEASE;
                end
            end
            DEBOUNCE: begin
                if (kind_c == KEYS_MULTI) begin
                    key_err_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = RELEASE;
                end else if (key == latched) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = CAPTURE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                capture_c = 1'b1;
                cnt_nxt   = '0;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                // Any activity restarts the count of consecutive idle samples
                if (key != '0) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Digit buffer and downstream handshake; clear beats transfer beats capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
        end else if (clear) begin
            digits      <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
        end else if (out_valid && out_ready) begin
            digits      <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
        end else if (capture_c && (digit_count < FULL)) begin
            digits      <= DIG_W'({digits, bcd_c});
            digit_count <= digit_count + 3'd1;
            out_valid   <= ((digit_count + 3'd1) == FULL);
        end
    end

endmodule

// File: tb/tb_deci_entry_ctrl.sv
// Directed vector bench for deci_entry_ctrl with default parameters.
module tb_deci_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  key = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        out_valid;
    logic        key_err;

    int checks = 0;
    int errors = 0;
    int err_seen;
    int valid_seen;

    always #5 clk = ~clk;

    deci_entry_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .NUM_DIGITS      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key),
        .clear       (clear),
        .out_ready   (out_ready),
        .digits      (digits),
        .digit_count (digit_count),
        .out_valid   (out_valid),
        .key_err     (key_err)
    );

    typedef struct {
        logic [9:0]  key;
        logic        clr;
        logic        rdy;
        int          n;
        logic [15:0] digits;
        logic [2:0]  count;
        logic        valid;
        int          errs;
        int          vhigh;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] k(input int i);
        return 10'(1) << i;
    endfunction

    task automatic add(input logic [9:0] kv, input logic clr, input logic rdy, input int n,
                       input logic [15:0] d, input logic [2:0] c, input logic v,
                       input int errs, input int vh);
        vec_t e;
        e.key = kv; e.clr = clr; e.rdy = rdy; e.n = n;
        e.digits = d; e.count = c; e.valid = v; e.errs = errs; e.vhigh = vh;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (key_err === 1'b1) err_seen++;
        if (out_valid === 1'b1) valid_seen++;
    endtask

    initial begin
        // key, clear, ready, cycles, digits, count, valid, key_err cycles, valid cycles
        add(k(3), 0, 0, 6, 16'h0003, 1, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0003, 1, 0, 0, 0);
        add(k(7), 0, 0, 6, 16'h0037, 2, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0037, 2, 0, 0, 0);
        add(k(1), 0, 0, 6, 16'h0371, 3, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0371, 3, 0, 0, 0);
        add(k(9), 0, 0, 6, 16'h3719, 4, 1, 0, 1);
        add('0,   0, 0, 6, 16'h3719, 4, 1, 0, 6);
        add(k(8), 0, 0, 6, 16'h3719, 4, 1, 0, 6);
        add('0,   0, 0, 6, 16'h3719, 4, 1, 0, 6);
        add('0,   0, 1, 1, 16'h0000, 0, 0, 0, 0);
        add(k(5), 0, 0, 2, 16'h0000, 0, 0, 0, 0);
        add('0,   0, 0, 1, 16'h0000, 0, 0, 0, 0);
        add(k(5), 0, 0, 2, 16'h0000, 0, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0000, 0, 0, 0, 0);
        add(10'b0000100100, 0, 0, 3, 16'h0000, 0, 0, 1, 0);
        add('0,   0, 0, 6, 16'h0000, 0, 0, 0, 0);
        add(k(2), 0, 0, 6, 16'h0002, 1, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0002, 1, 0, 0, 0);
        add(k(4), 0, 0, 2, 16'h0002, 1, 0, 0, 0);
        add(k(4) | k(1), 0, 0, 1, 16'h0002, 1, 0, 1, 0);
        add('0,   0, 0, 6, 16'h0002, 1, 0, 0, 0);
        add(k(4), 0, 0, 2, 16'h0002, 1, 0, 0, 0);
        add(k(6), 0, 0, 4, 16'h0002, 1, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0002, 1, 0, 0, 0);
        add(k(5), 0, 0, 6, 16'h0025, 2, 0, 0, 0);
        add('0,   0, 0, 2, 16'h0025, 2, 0, 0, 0);
        add(k(5), 0, 0, 1, 16'h0025, 2, 0, 0, 0);
        add('0,   0, 0, 3, 16'h0025, 2, 0, 0, 0);
        add(k(7), 0, 0, 6, 16'h0025, 2, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0025, 2, 0, 0, 0);
        add(k(6), 0, 0, 5, 16'h0025, 2, 0, 0, 0);
        add(k(6), 1, 0, 1, 16'h0000, 0, 0, 0, 0);
        add('0,   0, 0, 6, 16'h0000, 0, 0, 0, 0);
        add(k(1), 0, 1, 6, 16'h0001, 1, 0, 0, 0);
        add('0,   0, 1, 6, 16'h0001, 1, 0, 0, 0);
        add(k(2), 0, 1, 6, 16'h0012, 2, 0, 0, 0);
        add('0,   0, 1, 6, 16'h0012, 2, 0, 0, 0);
        add(k(3), 0, 1, 6, 16'h0123, 3, 0, 0, 0);
        add('0,   0, 1, 6, 16'h0123, 3, 0, 0, 0);
        add(k(4), 0, 1, 6, 16'h1234, 4, 1, 0, 1);
        add('0,   0, 1, 6, 16'h0000, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset digits", 32'(digits), 0);
        chk("reset count", 32'(digit_count), 0);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset key_err", 32'(key_err), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            key = vecs[i].key;
            clear = vecs[i].clr;
            out_ready = vecs[i].rdy;
            err_seen = 0;
            valid_seen = 0;
            repeat (vecs[i].n) step();
            chk($sformatf("v%0d digits", i), 32'(digits), 32'(vecs[i].digits));
            chk($sformatf("v%0d count", i), 32'(digit_count), 32'(vecs[i].count));
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d key_err cycles", i), 32'(err_seen), 32'(vecs[i].errs));
            chk($sformatf("v%0d valid cycles", i), 32'(valid_seen), 32'(vecs[i].vhigh));
        end
        clear = 1'b0;
        out_ready = 1'b0;

        // key_err rises right after the multi-hot sample and lasts one cycle
        key = 10'b1000000001;
        step();
        chk("err pulse high", 32'(key_err), 1);
        key = '0;
        step();
        chk("err pulse low", 32'(key_err), 0);
        repeat (6) step();
        chk("err no capture", 32'(digit_count), 0);

        // Reset while debouncing abandons the press and returns to IDLE
        key = k(1);
        repeat (6) step();
        key = '0;
        repeat (6) step();
        chk("pre-reset digits", 32'(digits), 32'h1);
        chk("pre-reset count", 32'(digit_count), 1);
        key = k(3);
        repeat (2) step();
        rst_n = 1'b0;
        #2;
        chk("mid reset digits", 32'(digits), 0);
        chk("mid reset count", 32'(digit_count), 0);
        chk("mid reset valid", 32'(out_valid), 0);
        chk("mid reset key_err", 32'(key_err), 0);
        key = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post reset count", 32'(digit_count), 0);

        // Press latency: key seen at edges 0..4, digit lands on edge 5
        key = k(9);
        for (int e = 0; e <= 5; e++) begin
            step();
            chk($sformatf("latency edge %0d count", e), 32'(digit_count), (e == 5) ? 32'd1 : 32'd0);
        end
        chk("latency digits", 32'(digits), 32'h9);
        key = '0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deci_entry_ctrl.md
# deci_entry_ctrl

Sequencing controller for decimal key entry. It watches ten decimal key lines, debounces a single pressed key, and encodes it to a 4-bit BCD digit. The digit is shifted into a NUM_DIGITS-deep BCD buffer. When the buffer is full, the block presents the packed number downstream over a valid/ready handshake. It sits between raw decimal inputs (keypad or switches) and any BCD consumer such as a display driver or arithmetic unit.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required for press and for release; legal range 1..255.
- NUM_DIGITS, 4: buffer depth in BCD digits; legal range 1..7.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- key, input, 10: decimal key lines; key[i]=1 means digit i pressed; already synchronised to clk.
- clear, input, 1: synchronous buffer clear.
- out_ready, input, 1: downstream accepts the number.
- digits, output, 4*NUM_DIGITS: packed BCD; [3:0] is the newest digit.
- digit_count, output, 3: number of digits held, 0..NUM_DIGITS.
- out_valid, output, 1: buffer full and number presented.
- key_err, output, 1: one-cycle pulse when a multi-key press is detected.

## Operation
- Reset values: state IDLE, debounce counter 0, digits 0, digit_count 0, out_valid 0, key_err 0.
- FSM states:
  - IDLE:
    - key==0: stay in IDLE.
    - Exactly one bit set: latch the pattern, counter=0, go to DEBOUNCE.
    - More than one bit set: pulse key_err, go to RELEASE.
  - DEBOUNCE:
    - key equals the latched pattern and counter<DEBOUNCE_CYCLES-1: increment the counter.
    - key equals the latched pattern and counter==DEBOUNCE_CYCLES-1: go to CAPTURE.
    - key==0 or a different single bit: return to IDLE with no capture.
    - Multi-hot: pulse key_err, go to RELEASE.
  - CAPTURE (one cycle):
    - digit_count<NUM_DIGITS: digits <= {digits[4*NUM_DIGITS-5:0], bcd}, digit_count+1.
    - Buffer full: the digit is dropped silently.
    - Always go to RELEASE.
  - RELEASE:
    - Counter counts consecutive key==0 samples; any nonzero key resets it to 0.
    - key==0 with counter==DEBOUNCE_CYCLES-1: go to IDLE.
    - No key_err is raised in this state.
- Encoding: latched one-hot bit index i maps to BCD value i (4'd0..4'd9).
- out_valid is registered. It goes to 1 on the same edge digit_count reaches NUM_DIGITS.
- Transfer completes on an edge where out_valid&&out_ready. On that edge: digits=0, digit_count=0, out_valid=0.
- digits stays stable while out_valid=1.
- clear has highest priority: zeros digits, digit_count and out_valid on that edge, overriding both capture and transfer. The FSM is unaffected.
- Capture and transfer cannot coincide, because capture only writes when not full.

## Timing
- Press latency: a single key stable at sampling edges 0..DEBOUNCE_CYCLES updates digits and digit_count after edge DEBOUNCE_CYCLES+1. With the default of 4, the update appears after edge 5.
- Minimum press-to-next-press spacing: capture edge plus DEBOUNCE_CYCLES zero samples in RELEASE plus 1 cycle in IDLE.
- key_err is asserted for exactly one cycle, after the edge that sampled the multi-hot value.
- out_ready may be held high permanently. The transfer then occurs on the first edge with out_valid=1, so out_valid is high for one cycle.
- Reset mid-debounce or mid-release: the in-progress press is abandoned; no digit is written.

## Structure
- Shared package deci_pkg holds:
  - state enum (IDLE, DEBOUNCE, CAPTURE, RELEASE);
  - BCD_W=4 and KEY_W=10 constants;
  - a one-hot validity helper function (zero / single / multi).
- Sub-module dec_onehot_to_bcd: purely combinational, 10-bit one-hot in, 4-bit BCD out, 0 for illegal input. It is instantiated on the latched key pattern.
- Controller FSM, counter, digit buffer and handshake live in deci_entry_ctrl.

## Test plan
- Clean entry: press key[3], then key[7], then key[1], then key[9], each held 6 cycles with 6 idle cycles between (defaults). Required: digits=16'h3719, digit_count=4, out_valid=1; out_ready=1 then clears everything in one cycle.
- Bounce rejection: key[5] for 2 cycles, 0 for 1 cycle, key[5] for 2 cycles. Required: no capture, digit_count unchanged.
- Multi-key: key=10'b0000100100. Required: key_err high exactly one cycle, no digit captured; after release, key[2] captures 4'd2.
- Full buffer with out_ready=0: a fifth press (key[8]) is dropped. Required: digits still 16'h3719, out_valid stays 1 until out_ready.
- Clear and reset: assert clear during CAPTURE of key[6]. Required: digits=0, digit_count=0 afterwards. Separately, deassert rst_n mid-DEBOUNCE; after release all outputs are 0 and the state is IDLE.
